// File: rtl/m_fetch_pkg.sv
//==============================================================================
// Module   : m_fetch_pkg
// Purpose  : Shared widths, reset PC and PC step for the fetch front end,
//            plus the {pc, ir} instruction-queue entry type.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package m_fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam int unsigned     ILEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  // One decoded-side queue entry: the fetch PC and the returned instruction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/m_ifq.sv
//==============================================================================
// Module   : m_ifq
// Purpose  : Small synchronous FIFO with flush; head is read straight from
//            registered storage. Used as instruction queue and PC FIFO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module m_ifq #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_q, r_wr_q, w_rd_d, w_wr_d;
  logic [CW-1:0]    r_cnt_q, w_cnt_d;
  logic             w_do_push, w_do_pop;

  // Pointer advance with wrap for depths that are not a power of two.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_cnt_q == CW'(DEPTH));
  assign o_empty   = (r_cnt_q == '0);
  assign o_count   = r_cnt_q;
  assign o_data    = r_mem[r_rd_q];
  // A push into a full queue is accepted only when the head leaves the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Next pointers and occupancy; flush empties the queue and wins over push/pop.
  always_comb begin
    w_rd_d  = r_rd_q;
    w_wr_d  = r_wr_q;
    w_cnt_d = r_cnt_q;
    if (i_flush) begin
      w_rd_d  = '0;
      w_wr_d  = '0;
      w_cnt_d = '0;
    end else begin
      if (w_do_push) w_wr_d = f_next(r_wr_q);
      if (w_do_pop)  w_rd_d = f_next(r_rd_q);
      case ({w_do_push, w_do_pop})
        2'b10:   w_cnt_d = r_cnt_q + 1'b1;
        2'b01:   w_cnt_d = r_cnt_q - 1'b1;
        default: w_cnt_d = r_cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_q  <= '0;
      r_wr_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      r_rd_q  <= w_rd_d;
      r_wr_q  <= w_wr_d;
      r_cnt_q <= w_cnt_d;
    end
  end

  // Entry storage; cleared on reset so an empty queue presents zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_q] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/m_fetch.sv
//==============================================================================
// Module   : m_fetch
// Purpose  : Instruction fetch stage: credit-limited memory requests, in-order
//            PC pairing, instruction queue to decode, redirect with drain.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module m_fetch
  import m_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_redir,
  input  logic [XLEN-1:0] w_redir_pc,
  output logic            w_imem_req,
  output logic [XLEN-1:0] w_imem_addr,
  input  logic            w_imem_gnt,
  input  logic            w_imem_rvalid,
  input  logic [ILEN-1:0] w_imem_rdata,
  output logic            w_dec_valid,
  output logic [XLEN-1:0] w_dec_pc,
  output logic [ILEN-1:0] w_dec_ir,
  input  logic            w_dec_ready
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] r_pc_q, w_pc_d;
  logic [CW-1:0]   r_drop_q, w_drop_d;
  logic [CW-1:0]   w_out_cnt, w_iq_cnt;
  logic [CW:0]     w_inflight;
  logic [XLEN-1:0] w_rsp_pc;
  logic            w_pcq_full, w_pcq_empty, w_iq_full, w_iq_empty;
  logic            w_grant, w_drop_rsp, w_enq, w_deq;
  ifq_entry_t      w_iq_wdata, w_iq_head;
  logic            w_unused_lsb;

  assign w_unused_lsb = ^w_redir_pc[1:0];

  // Outstanding requests (including ones that will be dropped) plus queued
  // instructions never exceed the queue depth, so every response has a slot.
  assign w_inflight  = {1'b0, w_out_cnt} + {1'b0, w_iq_cnt};
  assign w_imem_req  = ~w_rst & ~w_redir & (w_inflight < (CW+1)'(QDEPTH));
  assign w_imem_addr = r_pc_q;
  assign w_grant     = w_imem_req & w_imem_gnt;

  // Responses are discarded in the redirect cycle and while stale ones drain.
  assign w_drop_rsp  = w_imem_rvalid & (w_redir | (r_drop_q != '0));
  assign w_enq       = w_imem_rvalid & ~w_drop_rsp;
  assign w_deq       = w_dec_valid & w_dec_ready;
  assign w_iq_wdata  = '{pc: w_rsp_pc, ir: w_imem_rdata};

  assign w_dec_valid = ~w_rst & ~w_iq_empty;
  assign w_dec_pc    = w_rst ? '0 : w_iq_head.pc;
  assign w_dec_ir    = w_rst ? '0 : w_iq_head.ir;

  // PC of every request in flight, popped as its response returns.
  m_ifq #(.DEPTH(QDEPTH), .WIDTH(XLEN)) u_pcq (
    .clk     (w_clk),
    .rst     (w_rst),
    .i_flush (1'b0),
    .i_push  (w_grant),
    .i_data  (r_pc_q),
    .i_pop   (w_imem_rvalid),
    .o_data  (w_rsp_pc),
    .o_full  (w_pcq_full),
    .o_empty (w_pcq_empty),
    .o_count (w_out_cnt)
  );

  // Instruction queue feeding decode; a redirect empties it.
  m_ifq #(.DEPTH(QDEPTH), .WIDTH($bits(ifq_entry_t))) u_iq (
    .clk     (w_clk),
    .rst     (w_rst),
    .i_flush (w_redir),
    .i_push  (w_enq),
    .i_data  (w_iq_wdata),
    .i_pop   (w_deq),
    .o_data  (w_iq_head),
    .o_full  (w_iq_full),
    .o_empty (w_iq_empty),
    .o_count (w_iq_cnt)
  );

  // Next fetch PC and drop count; a redirect marks everything still in flight as stale.
  always_comb begin
    w_pc_d   = r_pc_q;
    w_drop_d = r_drop_q;
    if (w_redir) begin
      w_pc_d   = {w_redir_pc[XLEN-1:2], 2'b00};
      w_drop_d = w_out_cnt - CW'(w_imem_rvalid);
    end else begin
      if (w_grant)    w_pc_d   = r_pc_q + PC_INC;
      if (w_drop_rsp) w_drop_d = r_drop_q - 1'b1;
    end
  end

  // Fetch PC and drop counter registers.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pc_q   <= RESET_PC;
      r_drop_q <= '0;
    end else begin
      r_pc_q   <= w_pc_d;
      r_drop_q <= w_drop_d;
    end
  end

  a_iq_no_overflow: assert property (@(posedge w_clk) disable iff (w_rst)
    !(w_imem_rvalid && w_iq_full));
  a_rsp_has_req: assert property (@(posedge w_clk) disable iff (w_rst)
    !(w_imem_rvalid && w_pcq_empty));
  a_pcq_room: assert property (@(posedge w_clk) disable iff (w_rst)
    !(w_grant && w_pcq_full));

endmodule

`default_nettype wire

// File: tb/tb_m_fetch.sv
//==============================================================================
// Module   : tb_m_fetch
// Purpose  : Self-checking bench for m_fetch: memory responder model, PC
//            scoreboard, cycle table for back-pressure, redirect/reset cases.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_m_fetch;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_redir = 1'b0;
  logic [31:0] w_redir_pc = '0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_gnt = 1'b1;
  logic        w_imem_rvalid = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_dec_valid;
  logic [31:0] w_dec_pc;
  logic [31:0] w_dec_ir;
  logic        w_dec_ready = 1'b0;

  m_fetch #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_redir       (w_redir),
    .w_redir_pc    (w_redir_pc),
    .w_imem_req    (w_imem_req),
    .w_imem_addr   (w_imem_addr),
    .w_imem_gnt    (w_imem_gnt),
    .w_imem_rvalid (w_imem_rvalid),
    .w_imem_rdata  (w_imem_rdata),
    .w_dec_valid   (w_dec_valid),
    .w_dec_pc      (w_dec_pc),
    .w_dec_ir      (w_dec_ir),
    .w_dec_ready   (w_dec_ready)
  );

  always #5 w_clk = ~w_clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } item_t;
  typedef struct { logic ready; logic req; logic [31:0] addr; logic dv; logic [31:0] pc; } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          dec_seen = 0;
  pend_t       pend[$];
  item_t       exp_q[$];
  logic [31:0] model_pc = '0;
  logic        s_grant, s_rst;
  logic [31:0] s_addr;
  vec_t        tbl[8];

  // Distinct instruction word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge: scoreboard the cycle, cross the edge, update memory.
  task automatic cyc_end();
    s_rst   = w_rst;
    s_grant = w_imem_req & w_imem_gnt;
    s_addr  = w_imem_addr;
    if (w_rst) begin
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      if (w_redir) check("req_in_redir", {31'b0, w_imem_req}, 32'h0);
      if (s_grant) begin
        check("imem_addr", w_imem_addr, model_pc);
        exp_q.push_back('{pc: w_imem_addr, ir: mem_word(w_imem_addr)});
        model_pc = model_pc + 32'd4;
      end
      if (w_dec_valid && w_dec_ready && !w_redir) begin
        dec_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL dec_unexpected: got pc %h, expected no item", w_dec_pc);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          check("dec_pc", w_dec_pc, e.pc);
          check("dec_ir", w_dec_ir, e.ir);
        end
      end
      if (w_redir) begin
        exp_q.delete();
        model_pc = {w_redir_pc[31:2], 2'b00};
      end
    end
    @(posedge w_clk);
    #1;
    cyc++;
    if (s_rst) pend.delete();
    else if (s_grant) pend.push_back('{addr: s_addr, due: cyc - 1 + lat});
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      w_imem_rvalid = 1'b1;
      w_imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      w_imem_rvalid = 1'b0;
      w_imem_rdata  = '0;
    end
  endtask

  task automatic tick();
    @(negedge w_clk);
    cyc_end();
  endtask

  // Three reset cycles with a reset-state check; returns at the first cycle after release.
  task automatic do_reset();
    w_rst = 1'b1;
    w_redir = 1'b0;
    w_dec_ready = 1'b0;
    tick();
    tick();
    @(negedge w_clk);
    check("rst_req", {31'b0, w_imem_req}, 32'h0);
    check("rst_dv", {31'b0, w_dec_valid}, 32'h0);
    check("rst_pc", w_dec_pc, 32'h0);
    check("rst_ir", w_dec_ir, 32'h0);
    cyc_end();
    w_rst = 1'b0;
  endtask

  task automatic wait_dec(input string name, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge w_clk);
      if (w_dec_valid) begin
        check(name, w_dec_pc, pc);
        seen = 1'b1;
      end
      cyc_end();
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no decode, expected pc %h", name, pc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-pressure table from reset release: ready, req, addr, dec_valid, dec_pc.
    tbl[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[7] = '{1'b1, 1'b1, 32'hC,  1'b0, 32'h0};

    // Streaming fill with single-cycle memory latency.
    lat = 1;
    do_reset();
    w_dec_ready = 1'b1;
    dec_seen = 0;
    repeat (12) tick();
    check("fill_decodes_ge3", {31'b0, (dec_seen >= 3)}, 32'h1);

    // Credit stall and resume.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      w_dec_ready = tbl[i].ready;
      @(negedge w_clk);
      check($sformatf("t%0d_req", i), {31'b0, w_imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) check($sformatf("t%0d_addr", i), w_imem_addr, tbl[i].addr);
      check($sformatf("t%0d_dv", i), {31'b0, w_dec_valid}, {31'b0, tbl[i].dv});
      if (tbl[i].dv) check($sformatf("t%0d_pc", i), w_dec_pc, tbl[i].pc);
      cyc_end();
    end
    repeat (4) tick();

    // Redirect with two requests outstanding; both stale responses are dropped.
    lat = 3;
    do_reset();
    w_dec_ready = 1'b1;
    tick();
    tick();
    w_redir = 1'b1;
    w_redir_pc = 32'h103;
    tick();
    w_redir = 1'b0;
    @(negedge w_clk);
    check("r37_addr", w_imem_addr, 32'h100);
    check("r37_req_draining", {31'b0, w_imem_req}, 32'h0);
    cyc_end();
    @(negedge w_clk);
    check("r37_refetch_req", {31'b0, w_imem_req}, 32'h1);
    check("r37_refetch_addr", w_imem_addr, 32'h100);
    cyc_end();
    wait_dec("r37_first_dec", 32'h100);
    repeat (4) tick();

    // Redirect coinciding with a decode handshake and a response.
    lat = 1;
    do_reset();
    tick();
    tick();
    w_dec_ready = 1'b1;
    w_redir = 1'b1;
    w_redir_pc = 32'h200;
    @(negedge w_clk);
    check("r38_dv_pre", {31'b0, w_dec_valid}, 32'h1);
    check("r38_pc_pre", w_dec_pc, 32'h0);
    cyc_end();
    w_redir = 1'b0;
    @(negedge w_clk);
    check("r38_dv_empty", {31'b0, w_dec_valid}, 32'h0);
    check("r38_req", {31'b0, w_imem_req}, 32'h1);
    check("r38_addr", w_imem_addr, 32'h200);
    cyc_end();
    wait_dec("r38_first_dec", 32'h200);
    repeat (3) tick();

    // Redirect to the top word; fetch wraps to zero.
    lat = 1;
    do_reset();
    w_dec_ready = 1'b1;
    tick();
    w_redir = 1'b1;
    w_redir_pc = 32'hFFFF_FFFC;
    tick();
    w_redir = 1'b0;
    @(negedge w_clk);
    check("r39_addr_top", w_imem_addr, 32'hFFFF_FFFC);
    check("r39_req_top", {31'b0, w_imem_req}, 32'h1);
    cyc_end();
    @(negedge w_clk);
    check("r39_addr_wrap", w_imem_addr, 32'h0);
    check("r39_req_wrap", {31'b0, w_imem_req}, 32'h1);
    cyc_end();
    wait_dec("r39_first_dec", 32'hFFFF_FFFC);
    repeat (3) tick();

    // Reset with one instruction queued and one response in flight.
    lat = 2;
    do_reset();
    tick();
    tick();
    tick();
    do_reset();
    @(negedge w_clk);
    check("r40_req", {31'b0, w_imem_req}, 32'h1);
    check("r40_addr", w_imem_addr, 32'h0);
    check("r40_dv", {31'b0, w_dec_valid}, 32'h0);
    cyc_end();
    w_dec_ready = 1'b1;
    wait_dec("r40_first_dec", 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
